// File: rtl/ddr_rd_cmd_sched.sv
// ddr_rd_cmd_sched: shares one DDR read-command port between two strided-burst
// descriptor channels. Each channel expands its descriptor into individual burst
// commands. The channels are round-robined at burst granularity. A channel reports
// done once every burst it issued has returned its last data beat.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ddrN_start               one-cycle pulse; captures the channel N descriptor
//   ddrN_st_addr/_burst/_step/_burst_num  descriptor fields
//   ddrN_done                level; channel N idle with its job complete
//   cmd_valid/ready/addr/len/id  burst command to the DDR read port
//   resp_valid/last/id       read data beats returned by the DDR port
//   err                      sticky; a completion arrived with nothing outstanding
module ddr_rd_cmd_sched #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ddr1_start,
    input  logic [ADDR_W-1:0] ddr1_st_addr,
    input  logic [LEN_W-1:0]  ddr1_burst,
    input  logic [ADDR_W-1:0] ddr1_step,
    input  logic [LEN_W-1:0]  ddr1_burst_num,
    output logic              ddr1_done,
    input  logic              ddr2_start,
    input  logic [ADDR_W-1:0] ddr2_st_addr,
    input  logic [LEN_W-1:0]  ddr2_burst,
    input  logic [ADDR_W-1:0] ddr2_step,
    input  logic [LEN_W-1:0]  ddr2_burst_num,
    output logic              ddr2_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_id,
    input  logic              resp_valid,
    input  logic              resp_last,
    input  logic              resp_id,
    output logic              err
);

    localparam int unsigned OW = $clog2(MAX_OUTS) + 1;
    localparam logic [OW:0] MaxOuts = (OW+1)'(MAX_OUTS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    // Channel inputs gathered into arrays so both channels share one description.
    logic              start    [2];
    logic [ADDR_W-1:0] in_addr  [2];
    logic [LEN_W-1:0]  in_burst [2];
    logic [ADDR_W-1:0] in_step  [2];
    logic [LEN_W-1:0]  in_num   [2];

    assign start[0]    = ddr1_start;
    assign start[1]    = ddr2_start;
    assign in_addr[0]  = ddr1_st_addr;
    assign in_addr[1]  = ddr2_st_addr;
    assign in_burst[0] = ddr1_burst;
    assign in_burst[1] = ddr2_burst;
    assign in_step[0]  = ddr1_step;
    assign in_step[1]  = ddr2_step;
    assign in_num[0]   = ddr1_burst_num;
    assign in_num[1]   = ddr2_burst_num;

    state_t            st        [2];
    logic [ADDR_W-1:0] next_addr [2];
    logic [ADDR_W-1:0] step      [2];
    logic [LEN_W-1:0]  blen      [2];
    logic [LEN_W-1:0]  remaining [2];
    logic [OW-1:0]     outs      [2];
    logic [1:0]        done_q;
    logic              last_gnt;

    logic [1:0]  pend, elig, take, hs, cpl;
    logic [OW:0] inflight [2];
    logic        load, gnt;

    assign ddr1_done = done_q[0];
    assign ddr2_done = done_q[1];
    assign load      = !cmd_valid || cmd_ready;
    // Both eligible: alternate; otherwise the single eligible channel wins.
    assign gnt       = (elig[0] && elig[1]) ? ~last_gnt : elig[1];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            pend[c]     = cmd_valid && (cmd_id == 1'(c));
            // A loaded but not yet accepted command already counts against the cap.
            inflight[c] = {1'b0, outs[c]} + (OW+1)'(pend[c]);
            elig[c]     = (st[c] == ISSUE) && (remaining[c] != '0) && (inflight[c] < MaxOuts);
            take[c]     = load && elig[c] && (gnt == 1'(c));
            hs[c]       = pend[c] && cmd_ready;
            cpl[c]      = resp_valid && resp_last && (resp_id == 1'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_id    <= 1'b0;
            last_gnt  <= 1'b1;
            err       <= 1'b0;
            done_q    <= 2'b11;
            for (int c = 0; c < 2; c++) begin
                st[c]        <= IDLE;
                next_addr[c] <= '0;
                step[c]      <= '0;
                blen[c]      <= '0;
                remaining[c] <= '0;
                outs[c]      <= '0;
            end
        end else begin
            if (load) begin
                cmd_valid <= |elig;
                if (|elig) begin
                    cmd_addr <= next_addr[gnt];
                    cmd_len  <= blen[gnt];
                    cmd_id   <= gnt;
                    last_gnt <= gnt;
                end
            end

            for (int c = 0; c < 2; c++) begin
                unique case (st[c])
                    IDLE: begin
                        if (start[c] && in_num[c] != '0 && in_burst[c] != '0) begin
                            next_addr[c] <= in_addr[c];
                            step[c]      <= in_step[c];
                            blen[c]      <= in_burst[c];
                            remaining[c] <= in_num[c];
                            done_q[c]    <= 1'b0;
                            st[c]        <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (take[c]) begin
                            remaining[c] <= remaining[c] - LEN_W'(1);
                            next_addr[c] <= next_addr[c] + step[c];
                        end
                        // Leave only once the final loaded burst has been accepted.
                        if (remaining[c] == '0 && (!pend[c] || cmd_ready)) begin
                            st[c] <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (outs[c] == '0) begin
                            done_q[c] <= 1'b1;
                            st[c]     <= IDLE;
                        end
                    end
                    default: st[c] <= IDLE;
                endcase

                if (cpl[c] && outs[c] == '0) begin
                    err <= 1'b1;
                end
                if (hs[c] && !(cpl[c] && outs[c] != '0)) begin
                    outs[c] <= outs[c] + OW'(1);
                end else if (!hs[c] && cpl[c] && outs[c] != '0) begin
                    outs[c] <= outs[c] - OW'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(ddr1_start && st[0] != IDLE)) else $error("ddr1_start while busy");
            assert (!(ddr2_start && st[1] != IDLE)) else $error("ddr2_start while busy");
        end
    end
`endif

endmodule

// File: tb/tb_ddr_rd_cmd_sched.sv
module tb_ddr_rd_cmd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ddr1_start, ddr2_start;
    logic [31:0] ddr1_st_addr, ddr2_st_addr, ddr1_step, ddr2_step;
    logic [15:0] ddr1_burst, ddr2_burst, ddr1_burst_num, ddr2_burst_num;
    logic        ddr1_done, ddr2_done;
    logic        cmd_valid, cmd_ready, cmd_id;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        resp_valid, resp_last, resp_id;
    logic        err;

    ddr_rd_cmd_sched #(.ADDR_W(32), .LEN_W(16), .MAX_OUTS(4)) dut (
        .clk(clk), .rst(rst),
        .ddr1_start(ddr1_start), .ddr1_st_addr(ddr1_st_addr), .ddr1_burst(ddr1_burst),
        .ddr1_step(ddr1_step), .ddr1_burst_num(ddr1_burst_num), .ddr1_done(ddr1_done),
        .ddr2_start(ddr2_start), .ddr2_st_addr(ddr2_st_addr), .ddr2_burst(ddr2_burst),
        .ddr2_step(ddr2_step), .ddr2_burst_num(ddr2_burst_num), .ddr2_done(ddr2_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_id(cmd_id),
        .resp_valid(resp_valid), .resp_last(resp_last), .resp_id(resp_id),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ch;
        logic [31:0] addr;
        logic [15:0] len;
        logic [31:0] step;
        logic [15:0] num;
    } job_t;

    typedef struct {
        bit          id;
        logic [31:0] addr;
        logic [15:0] len;
    } cmd_t;

    cmd_t exp_q[$];
    bit   rq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;
    int   budget  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted command is compared with the next expected one.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            hs_cnt++;
            rq.push_back(cmd_id);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_cmd: got id %0d addr %0h len %0h expected none",
                         cmd_id, cmd_addr, cmd_len);
            end else begin
                cmd_t e;
                e = exp_q.pop_front();
                check("cmd", {15'b0, cmd_id, cmd_addr, cmd_len}, {15'b0, e.id, e.addr, e.len});
            end
        end
    end

    // Responder: returns one last beat per accepted command while budget lasts.
    initial begin
        resp_valid = 1'b0;
        resp_last  = 1'b0;
        resp_id    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && budget > 0 && rq.size() > 0) begin
                resp_valid = 1'b1;
                resp_last  = 1'b1;
                resp_id    = rq.pop_front();
                budget--;
            end else begin
                resp_valid = 1'b0;
                resp_last  = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input bit ch, input logic [31:0] a, input logic [15:0] l,
                            input logic [31:0] s, input logic [15:0] n);
        if (!ch) begin
            ddr1_st_addr = a; ddr1_burst = l; ddr1_step = s; ddr1_burst_num = n;
        end else begin
            ddr2_st_addr = a; ddr2_burst = l; ddr2_step = s; ddr2_burst_num = n;
        end
    endtask

    // Start pulse lasts exactly one sampling edge; returns 1 time unit after it.
    task automatic pulse(input logic [1:0] m);
        ddr1_start = m[0];
        ddr2_start = m[1];
        tick(1);
        ddr1_start = 1'b0;
        ddr2_start = 1'b0;
    endtask

    task automatic push_exp(input bit id, input logic [31:0] a, input logic [15:0] l);
        cmd_t e;
        e.id = id; e.addr = a; e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(ddr1_done && ddr2_done && exp_q.size() == 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle_timeout"}, 64'(k < 300), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 64'(cmd_valid), 64'd0);
        check({name, "_addr"},  64'(cmd_addr),  64'd0);
        check({name, "_len"},   64'(cmd_len),   64'd0);
        check({name, "_id"},    64'(cmd_id),    64'd0);
        check({name, "_done"},  64'({ddr2_done, ddr1_done}), 64'd3);
        check({name, "_err"},   64'(err),       64'd0);
    endtask

    job_t jobs[5];

    initial begin
        int base;
        jobs[0] = '{ch: 1'b0, addr: 32'h0000_1000, len: 16'd64, step: 32'h400, num: 16'd3};
        jobs[1] = '{ch: 1'b1, addr: 32'hFFFF_FF00, len: 16'd8,  step: 32'h100, num: 16'd2};
        jobs[2] = '{ch: 1'b0, addr: 32'h0000_5000, len: 16'd4,  step: 32'h10,  num: 16'd0};
        jobs[3] = '{ch: 1'b1, addr: 32'h0000_6000, len: 16'd0,  step: 32'h10,  num: 16'd4};
        jobs[4] = '{ch: 1'b1, addr: 32'h0003_0000, len: 16'd32, step: 32'h80,  num: 16'd5};

        rst = 1'b1;
        ddr1_start = 1'b0;
        ddr2_start = 1'b0;
        cmd_ready  = 1'b1;
        set_desc(1'b0, '0, '0, '0, '0);
        set_desc(1'b1, '0, '0, '0, '0);
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Single job with exact timing: done drops right after the start edge,
        // first command after the next edge, three back-to-back handshakes.
        set_desc(1'b0, 32'h1000, 16'd64, 32'h400, 16'd3);
        push_exp(1'b0, 32'h1000, 16'd64);
        push_exp(1'b0, 32'h1400, 16'd64);
        push_exp(1'b0, 32'h1800, 16'd64);
        base = hs_cnt;
        pulse(2'b01);
        check("single_done_low", 64'(ddr1_done), 64'd0);
        check("single_no_cmd_yet", 64'(cmd_valid), 64'd0);
        tick(1);
        check("single_first_valid", 64'(cmd_valid), 64'd1);
        tick(3);
        check("single_hs_count", 64'(hs_cnt - base), 64'd3);
        check("single_valid_drop", 64'(cmd_valid), 64'd0);
        check("single_still_busy", 64'(ddr1_done), 64'd0);
        budget = 1000;
        wait_idle("single");

        // Table-driven jobs, including zero-length and address-wrap corners.
        for (int j = 0; j < 5; j++) begin
            logic [31:0] a;
            bit          active;
            active = (jobs[j].num != 0) && (jobs[j].len != 0);
            a = jobs[j].addr;
            if (active) begin
                for (int i = 0; i < int'(jobs[j].num); i++) begin
                    push_exp(jobs[j].ch, a, jobs[j].len);
                    a = a + jobs[j].step;
                end
            end
            base = hs_cnt;
            set_desc(jobs[j].ch, jobs[j].addr, jobs[j].len, jobs[j].step, jobs[j].num);
            pulse(jobs[j].ch ? 2'b10 : 2'b01);
            check($sformatf("job%0d_done_after_start", j),
                  64'(jobs[j].ch ? ddr2_done : ddr1_done), 64'(!active));
            tick(5);
            wait_idle($sformatf("job%0d", j));
            check($sformatf("job%0d_cmds", j), 64'(hs_cnt - base),
                  active ? 64'(jobs[j].num) : 64'd0);
        end

        // Arbitration: both started together.
        set_desc(1'b0, 32'h0,    16'd8, 32'h100, 16'd2);
        set_desc(1'b1, 32'h8000, 16'd8, 32'h40,  16'd3);
        push_exp(1'b0, 32'h0,    16'd8);
        push_exp(1'b1, 32'h8000, 16'd8);
        push_exp(1'b0, 32'h100,  16'd8);
        push_exp(1'b1, 32'h8040, 16'd8);
        push_exp(1'b1, 32'h8080, 16'd8);
        pulse(2'b11);
        wait_idle("arb");

        // Backpressure: command held stable for 5 cycles.
        cmd_ready = 1'b0;
        set_desc(1'b0, 32'h2000, 16'd16, 32'h10, 16'd3);
        push_exp(1'b0, 32'h2000, 16'd16);
        push_exp(1'b0, 32'h2010, 16'd16);
        push_exp(1'b0, 32'h2020, 16'd16);
        pulse(2'b01);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {15'b0, cmd_valid, cmd_addr, cmd_len, cmd_id},
                  {15'b0, 1'b1, 32'h2000, 16'd16, 1'b0});
        end
        tick(1);
        cmd_ready = 1'b1;
        wait_idle("bp");

        // Outstanding cap: no responses allowed, so only 4 commands go out.
        budget = 0;
        set_desc(1'b1, 32'h100, 16'd4, 32'h20, 16'd6);
        for (int i = 0; i < 6; i++) push_exp(1'b1, 32'h100 + 32'(i) * 32'h20, 16'd4);
        base = hs_cnt;
        pulse(2'b10);
        tick(10);
        check("cap_hs4", 64'(hs_cnt - base), 64'd4);
        check("cap_valid_low", 64'(cmd_valid), 64'd0);
        budget = 1;
        tick(10);
        check("cap_hs5", 64'(hs_cnt - base), 64'd5);
        check("cap_valid_low2", 64'(cmd_valid), 64'd0);
        budget = 1000;
        wait_idle("cap");
        check("no_err_before_stray", 64'(err), 64'd0);

        // Stray completion while idle.
        tick(2);
        rq.push_back(1'b1);
        tick(4);
        check("stray_err", 64'(err), 64'd1);
        check("stray_done", 64'({ddr2_done, ddr1_done}), 64'd3);

        // Reset in the middle of a 5-burst job.
        budget = 0;
        set_desc(1'b0, 32'h4000, 16'd2, 32'h8, 16'd5);
        for (int i = 0; i < 5; i++) push_exp(1'b0, 32'h4000 + 32'(i) * 32'h8, 16'd2);
        base = hs_cnt;
        pulse(2'b01);
        begin
            int k;
            k = 0;
            while (hs_cnt - base < 2 && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("rst_wait_two", 64'(hs_cnt - base), 64'd2);
        end
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        rq.delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        budget = 1000;
        set_desc(1'b0, 32'h9000, 16'd12, 32'h200, 16'd2);
        push_exp(1'b0, 32'h9000, 16'd12);
        push_exp(1'b0, 32'h9200, 16'd12);
        pulse(2'b01);
        wait_idle("post_rst");
        check("post_rst_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_rd_cmd_sched.md
Name: ddr_rd_cmd_sched

Overview:
Shares the single DDR read-command port between the two strided-burst descriptor channels (ddr1, ddr2) emitted by the buffer-configuration logic. Each descriptor gives a start address, burst length, address step and burst count. The block expands each descriptor into individual burst commands and round-robins between the channels at burst granularity. It tracks outstanding bursts per channel and reports a level done per channel once every burst of its job has returned its last data beat.

Parameters:
ADDR_W, 32, DDR byte-address width (matches DDR_ADDR_W)
LEN_W, 16, burst length and burst count width (matches BURST_W)
MAX_OUTS, 4, max outstanding (issued, not yet completed) bursts per channel; power of two, at least 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ddr1_start  in  1  one-cycle pulse; capture channel-1 descriptor
ddr1_st_addr  in  ADDR_W  first burst address
ddr1_burst  in  LEN_W  length of each burst
ddr1_step  in  ADDR_W  address increment between bursts
ddr1_burst_num  in  LEN_W  number of bursts
ddr1_done  out  1  level; high = channel 1 idle, job complete
ddr2_start, ddr2_st_addr, ddr2_burst, ddr2_step, ddr2_burst_num, ddr2_done  same as channel 1, for channel 2
cmd_valid  out  1  burst command valid
cmd_ready  in  1  DDR read port accepts command
cmd_addr  out  ADDR_W  burst address
cmd_len  out  LEN_W  burst length
cmd_id  out  1  0 = channel 1, 1 = channel 2
resp_valid  in  1  read data beat valid
resp_last  in  1  last beat of a burst
resp_id  in  1  channel of the beat
err  out  1  sticky; completion received for a channel with zero outstanding

Behaviour:
- Reset (async assert, takes effect immediately): cmd_valid=0, cmd_addr=0, cmd_len=0, cmd_id=0, ddr1_done=1, ddr2_done=1, err=0. All counters clear, channel FSMs go to IDLE, RR pointer favours channel 1. Assertion mid-job aborts the job; no completions are owed afterwards.
- Per-channel FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE + start, with burst_num!=0 and burst!=0: latch the descriptor, set next_addr=st_addr and remaining=burst_num, drive done=0 from the next edge, go to ISSUE.
- IDLE + start with burst_num==0 or burst==0: ignored; done stays 1.
- start outside IDLE: ignored (simulation assertion); the current job is unaffected.
- ISSUE: channel is eligible when remaining!=0 and outstanding<MAX_OUTS. When remaining reaches 0 on a handshake, go to DRAIN.
- DRAIN: when outstanding==0, go to IDLE; done=1 on the same edge. If the last completion coincides with the last issue, outstanding is still 1, so no early exit.
- Command register loads when !cmd_valid || cmd_ready:
  - If one channel is eligible, grant it.
  - If both are eligible, grant the channel not granted last; the pointer updates on each load.
  - Load cmd_addr=next_addr, cmd_len=burst, cmd_id=channel; decrement that channel's remaining; next_addr += step (modulo 2^ADDR_W, wrap silently).
  - Eligibility counts a burst as consumed once it is loaded; remaining decrements on load, not on handshake.
- cmd_valid is held with addr/len/id stable until cmd_ready. A back-to-back handshake and reload every cycle is permitted, giving sustained 1 command/cycle.
- Latency: start at edge N -> cmd_valid=1 after edge N+1 (earliest), provided the register is free.
- outstanding[c]: +1 on cmd handshake with cmd_id=c; -1 on resp_valid&&resp_last&&resp_id=c. If both happen in the same cycle, unchanged. Width is log2(MAX_OUTS)+1.
- resp_valid&&resp_last for a channel with outstanding==0: ignored, err<=1 (sticky until reset). Beats without resp_last do not affect state.
- done is a registered level, glitch-free. A start accepted in the same cycle that done returns high is legal only from the next cycle.

Test Plan:
- Single job: ddr1 st_addr=0x1000, burst=64, step=0x400, burst_num=3, cmd_ready=1 -> commands 0x1000/0x1400/0x1800, len 64, id 0, on consecutive cycles; ddr1_done low from start+1; after 3 resp_last, done=1 on the following edge.
- Arbitration: both channels started together (ch1 base 0x0 step 0x100 num 2; ch2 base 0x8000 step 0x40 num 3) -> id sequence 0,1,0,1,1; addresses 0x0, 0x8000, 0x100, 0x8040, 0x8080.
- Backpressure: cmd_ready low 5 cycles while cmd_valid=1 -> addr/len/id stable throughout; no remaining decrement beyond the held load.
- Outstanding cap: MAX_OUTS=4, burst_num=6, no responses -> exactly 4 handshakes then cmd_valid=0; one resp_last -> exactly one more command.
- Corners:
  - burst_num=0 start -> no command, done stays 1.
  - st_addr=0xFFFFFF00, step=0x100, num 2 -> second address 0x00000000.
  - Stray resp_last for id 1 while idle -> err=1.
- Reset mid-job: assert rst after 2 of 5 commands -> all outputs at reset values immediately; a new start then runs a clean job with no err.
